// File: rtl/sat_pkg.sv
// Shared types and helpers for the saturating requantiser.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sat_pkg;

    // Rounding selections carried alongside each sample; code 3 behaves as truncate.
    typedef enum logic [1:0] {
        RND_TRUNC     = 2'd0,
        RND_HALF_UP   = 2'd1,
        RND_HALF_EVEN = 2'd2,
        RND_TRUNC_ALT = 2'd3
    } rnd_mode_e;

    // Clamp a sign-extended value into the signed range of an out_w-bit result.
    // The caller keeps the low out_w bits.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value,
                                                     input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        else
            return value;
    endfunction

    // True when value does not fit in a signed out_w-bit result.
    function automatic logic sat_overflow(input logic signed [63:0] value,
                                          input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (value > hi) || (value < lo);
    endfunction

endpackage

// File: rtl/sat_round_stage.sv
// Combinational round-and-arithmetic-shift of one signed sample.
// Latency: 0 cycles (pure logic).
// Backpressure: none; the caller decides when to register the result.
module sat_round_stage
    import sat_pkg::*;
#(
    parameter int IN_W  = 24,
    parameter int SHIFT = 8
) (
    input  logic signed [IN_W-1:0] x,
    input  logic        [1:0]      mode,
    output logic signed [IN_W:0]   y
);

    generate
        if (SHIFT == 0) begin : g_pass
            // No fractional bits are discarded, so every mode is an identity.
            logic [1:0] unused_mode;
            assign unused_mode = mode;
            assign y = {x[IN_W-1], x};
        end else begin : g_round
            localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) <<< (SHIFT - 1);
            logic signed [IN_W:0] xe;
            logic signed [IN_W:0] add;
            logic signed [IN_W:0] sum;

            // Add the rounding bias one bit wider than the input so the carry never wraps.
            always_comb begin
                xe = {x[IN_W-1], x};
                case (rnd_mode_e'(mode))
                    RND_HALF_UP:   add = HALF;
                    // Ties go to the even kept value: bias is HALF-1 plus the kept LSB.
                    RND_HALF_EVEN: add = x[SHIFT] ? HALF : HALF - (IN_W+1)'(1);
                    default:       add = '0;
                endcase
                sum = xe + add;
                y   = sum >>> SHIFT;
            end
        end
    endgenerate

endmodule

// File: rtl/sat_round_pipe.sv
// Requantiser: round/shift a signed sample, saturate to OUT_W, keep sticky per-channel clamp flags.
// Latency: 2 cycles from accepted input to out_valid; 1 sample/cycle when unstalled.
// Backpressure: single global enable (~out_valid | out_ready) freezes both stages; in_ready mirrors it.
// Optional: define SAT_ROUND_PIPE_STATS_EN to add the 32-bit saturating sat_count output.
module sat_round_pipe
    import sat_pkg::*;
#(
    parameter int IN_W   = 24,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 8,
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic        [CH_W-1:0]  in_ch,
    input  logic        [1:0]       rnd_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic        [CH_W-1:0]  out_ch,
    output logic                    out_sat,
    output logic        [NUM_CH-1:0] sat_flags,
    input  logic        [NUM_CH-1:0] clr_flags
`ifdef SAT_ROUND_PIPE_STATS_EN
    ,
    output logic        [31:0]      sat_count
`endif
);

    logic                   en;
    logic                   out_xfer;
    logic signed [IN_W:0]   rs_y;
    logic                   s1_valid;
    logic signed [IN_W:0]   s1_y;
    logic        [CH_W-1:0] s1_ch;
    logic signed [63:0]     s1_wide;
    logic [NUM_CH-1:0]      set_vec;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;
    assign out_xfer = out_valid & out_ready;
    assign s1_wide  = 64'(s1_y);

    sat_round_stage #(
        .IN_W  (IN_W),
        .SHIFT (SHIFT)
    ) u_round (
        .x    (in_data),
        .mode (rnd_mode),
        .y    (rs_y)
    );

    // Stage 1: capture the rounded, shifted sample; an idle input advances as a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_y     <= '0;
            s1_ch    <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_y  <= rs_y;
                s1_ch <= in_ch;
            end
        end
    end

    // Stage 2: saturate into the output register; data only changes when a real sample arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= OUT_W'(sat_clamp(s1_wide, OUT_W));
                out_sat  <= sat_overflow(s1_wide, OUT_W);
                out_ch   <= s1_ch;
            end
        end
    end

    // Decode which flag a clamped output transfer sets; out-of-range tags match no bit.
    always_comb begin
        set_vec = '0;
        for (int i = 0; i < NUM_CH; i++)
            set_vec[i] = out_xfer & out_sat & (out_ch == CH_W'(i));
    end

    // Sticky flags: a set in the same cycle as its clear wins so no event is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_flags <= '0;
        else
            sat_flags <= (sat_flags & ~clr_flags) | set_vec;
    end

`ifdef SAT_ROUND_PIPE_STATS_EN
    // Clamp event counter: any clear restarts it (counting a coincident event), and it sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_count <= '0;
        else if (|clr_flags)
            sat_count <= {31'd0, out_xfer & out_sat};
        else if (out_xfer && out_sat && sat_count != 32'hFFFF_FFFF)
            sat_count <= sat_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_sat_round_pipe.sv
// Self-checking bench for sat_round_pipe with a rounding/saturation reference model.
// Latency: checks the 2-cycle fill and stream order under random stalls.
// Backpressure: randomly throttles out_ready and checks in_ready and output stability.
module tb_sat_round_pipe;

    localparam int IN_W   = 17;
    localparam int OUT_W  = 16;
    localparam int SHIFT  = 1;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_data;
    logic        [CH_W-1:0]  in_ch;
    logic        [1:0]       rnd_mode;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic        [CH_W-1:0]  out_ch;
    logic                    out_sat;
    logic [NUM_CH-1:0]       sat_flags;
    logic [NUM_CH-1:0]       clr_flags;
`ifdef SAT_ROUND_PIPE_STATS_EN
    logic [31:0]             sat_count;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [CH_W-1:0]  ch;
        logic             sat;
    } res_t;

    res_t exp_q[$];
    res_t got_q[$];
    int   stall_changes = 0;
    logic prev_stall = 1'b0;
    res_t prev_out;

    sat_round_pipe #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .NUM_CH(NUM_CH), .CH_W(CH_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_ch(in_ch), .rnd_mode(rnd_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_sat(out_sat),
        .sat_flags(sat_flags), .clr_flags(clr_flags)
`ifdef SAT_ROUND_PIPE_STATS_EN
        , .sat_count(sat_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference: exact floor division, then rounding by remainder, then range clamp.
    function automatic res_t model(input longint x, input int mode, input int ch);
        longint d, rem, q, hi, lo;
        res_t r;
        d   = longint'(1) << SHIFT;
        rem = ((x % d) + d) % d;
        q   = (x - rem) / d;
        if (mode == 1 && 2 * rem >= d)
            q = q + 1;
        else if (mode == 2 && (2 * rem > d || (2 * rem == d && (q & 1) != 0)))
            q = q + 1;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -hi - 1;
        r.sat = (q > hi) || (q < lo);
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        r.data = OUT_W'(q);
        r.ch   = CH_W'(ch);
        return r;
    endfunction

    // Observe transfers on the falling edge, when inputs and outputs are settled.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (in_valid && in_ready)
                exp_q.push_back(model(in_data, int'(rnd_mode), int'(in_ch)));
            if (out_valid && out_ready)
                got_q.push_back(res_t'({out_data, out_ch, out_sat}));
            if (prev_stall && (out_valid !== 1'b1 || res_t'({out_data, out_ch, out_sat}) !== prev_out))
                stall_changes++;
            prev_stall = out_valid && !out_ready;
            prev_out   = res_t'({out_data, out_ch, out_sat});
        end
    end

    task automatic drive_one(input logic signed [IN_W-1:0] x, input logic [1:0] m,
                             input logic [CH_W-1:0] c);
        int  t;
        logic ok;
        t = 0;
        in_valid = 1'b1; in_data = x; rnd_mode = m; in_ch = c;
        forever begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1;
            if (ok) break;
            t++;
            if (t > 100) begin
                checks++; errors++;
                $display("FAIL drive_timeout: in_ready stayed %0b, required 1", in_ready);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++; if (out_ch !== '0) begin errors++; $display("FAIL reset_out_ch: got %h want 0", out_ch); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat: got %b want 0", out_sat); end
        checks++; if (sat_flags !== '0) begin errors++; $display("FAIL reset_sat_flags: got %b want 0", sat_flags); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef SAT_ROUND_PIPE_STATS_EN
        checks++; if (sat_count !== 32'd0) begin errors++; $display("FAIL reset_sat_count: got %0d want 0", sat_count); end
`endif
    endtask

    task automatic test_vectors();
        logic signed [IN_W-1:0] vx [9] = '{17'h0FFFF, 17'h10000, 17'h1FFFD, 17'd1, 17'd3,
                                           17'd5, 17'd7, 17'h1FFFD, 17'h1FFFD};
        logic [1:0]       vm [9] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd3};
        logic [CH_W-1:0]  vc [9] = '{2'd2, 2'd0, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd1};
        logic [OUT_W-1:0] vd [9] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000, 16'h0002,
                                     16'h0002, 16'h0004, 16'hFFFE, 16'hFFFE};
        logic             vs [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        res_t g;
        out_ready = 1'b1;
        exp_q.delete(); got_q.delete();
        drive_one(vx[0], vm[0], vc[0]);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: out_valid %b want 0", out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_2cyc: out_valid %b want 1", out_valid); end
        for (int i = 1; i < 9; i++) drive_one(vx[i], vm[i], vc[i]);
        repeat (5) @(posedge clk); #1;
        checks++;
        if (got_q.size() != 9) begin errors++; $display("FAIL vec_count: got %0d outputs want 9", got_q.size()); end
        for (int i = 0; i < 9 && i < got_q.size(); i++) begin
            g = got_q[i];
            checks++; if (g.data !== vd[i] || g.ch !== vc[i]) begin errors++; $display("FAIL vec_data[%0d]: got %h ch%0d want %h ch%0d", i, g.data, g.ch, vd[i], vc[i]); end
            checks++; if (g.sat !== vs[i]) begin errors++; $display("FAIL vec_sat[%0d]: got %b want %b", i, g.sat, vs[i]); end
        end
        checks++; if (sat_flags !== 4'b0100) begin errors++; $display("FAIL vec_flags: got %b want 0100", sat_flags); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_random();
        logic [NUM_CH-1:0] exp_flags;
        clr_flags = '1; @(posedge clk); #1; clr_flags = '0;
        exp_q.delete(); got_q.delete();
        for (int c = 0; c < 300; c++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 5))
                0:       in_data = 17'h0FFFF;
                1:       in_data = 17'h10000;
                2:       in_data = 17'h0FFFE;
                default: in_data = IN_W'($urandom);
            endcase
            rnd_mode  = 2'($urandom);
            in_ch     = CH_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            checks++; if (in_ready !== (!out_valid || out_ready)) begin errors++; $display("FAIL rnd_in_ready: got %b want %b", in_ready, (!out_valid || out_ready)); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk); #1;
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        exp_flags = '0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (exp_q[i].sat) exp_flags[exp_q[i].ch] = 1'b1;
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_out[%0d]: got %h/%0d/%b want %h/%0d/%b", i, got_q[i].data, got_q[i].ch, got_q[i].sat, exp_q[i].data, exp_q[i].ch, exp_q[i].sat); end
        end
        checks++; if (sat_flags !== exp_flags) begin errors++; $display("FAIL rnd_flags: got %b want %b", sat_flags, exp_flags); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_back_to_back();
        logic signed [IN_W-1:0] vals [8];
        int sent;
        for (int i = 0; i < 8; i++) vals[i] = IN_W'($urandom);
        exp_q.delete(); got_q.delete();
        stall_changes = 0; sent = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid  = (sent < 8);
            in_data   = vals[sent % 8];
            rnd_mode  = 2'(sent);
            in_ch     = CH_W'(sent);
            out_ready = !(c >= 3 && c <= 5);
            @(negedge clk);
            if (c >= 3 && c <= 5) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready[c%0d]: got %b want 0", c, in_ready); end
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        checks++; if (sent != 8) begin errors++; $display("FAIL b2b_sent: got %0d want 8", sent); end
        checks++; if (got_q.size() != 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_out[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (stall_changes != 0) begin errors++; $display("FAIL b2b_stable: %0d changes while stalled, want 0", stall_changes); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_flags();
        clr_flags = '1; @(posedge clk); #1; clr_flags = '0;
        out_ready = 1'b0;
        drive_one(17'h0FFFF, 2'd1, 2'd1);
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_sat !== 1'b1) begin errors++; $display("FAIL flag_hold: valid %b sat %b want 1 1", out_valid, out_sat); end
        out_ready = 1'b1; clr_flags = 4'b0010;
        @(posedge clk); #1;
        clr_flags = '0;
        checks++; if (sat_flags !== 4'b0010) begin errors++; $display("FAIL flag_set_wins: got %b want 0010", sat_flags); end
`ifdef SAT_ROUND_PIPE_STATS_EN
        checks++; if (sat_count !== 32'd1) begin errors++; $display("FAIL count_clr_inc: got %0d want 1", sat_count); end
`endif
        clr_flags = 4'b0010;
        @(posedge clk); #1;
        clr_flags = '0;
        checks++; if (sat_flags !== 4'b0000) begin errors++; $display("FAIL flag_clear: got %b want 0000", sat_flags); end
`ifdef SAT_ROUND_PIPE_STATS_EN
        checks++; if (sat_count !== 32'd0) begin errors++; $display("FAIL count_clear: got %0d want 0", sat_count); end
`endif
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        drive_one(17'h0FFFF, 2'd1, 2'd3);
        repeat (3) @(posedge clk); #1;
        checks++; if (sat_flags[3] !== 1'b1) begin errors++; $display("FAIL mid_preflag: got %b want 1", sat_flags[3]); end
        out_ready = 1'b0;
        drive_one(17'd5, 2'd0, 2'd0);
        drive_one(17'd7, 2'd0, 2'd1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight: out_valid %b want 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b want 0", out_valid); end
        checks++; if (sat_flags !== '0) begin errors++; $display("FAIL mid_async_flags: got %b want 0", sat_flags); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL mid_async_data: got %h want 0", out_data); end
        exp_q.delete(); got_q.delete();
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk); #1;
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mid_no_output: got %0d outputs want 0", got_q.size()); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_after: got %b want 0", out_valid); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ch = '0; rnd_mode = '0;
        out_ready = 1'b0; clr_flags = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        test_flags();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sat_round_pipe.md
Name: sat_round_pipe

Overview:
- Parametrised, pipelined requantiser: arithmetic right shift of a signed IN_W sample by SHIFT, selectable rounding, symmetric-range-free saturation to OUT_W.
- Streams with valid/ready backpressure and carries a channel tag; keeps per-channel sticky saturation flags.
- Sits between wide MAC/accumulator outputs and the 16-bit audio datapath. Replaces ad-hoc combinational clamps wherever a registered, flow-controlled boundary is needed.

Parameters:
- IN_W, 24, input sample width (signed); must be ≥ OUT_W + SHIFT.
- OUT_W, 16, output sample width (signed).
- SHIFT, 8, right-shift amount; 0 is legal and makes rounding a no-op.
- NUM_CH, 4, number of channels tagged on the stream; ≥1.
- CH_W, 2, tag width = max(1, clog2(NUM_CH)).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept input this cycle.
- in_data  in  IN_W  signed input sample.
- in_ch  in  CH_W  channel tag; values ≥ NUM_CH are passed through but do not set flags.
- rnd_mode  in  2  0 = truncate (floor), 1 = round half up, 2 = round half to even, 3 = truncate. Sampled with each accepted input.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_W  saturated result.
- out_ch  out  CH_W  tag aligned with out_data.
- out_sat  out  1  this output was clamped.
- sat_flags  out  NUM_CH  sticky per-channel saturation flags.
- clr_flags  in  NUM_CH  per-bit clear of sat_flags, single-cycle pulse.

Behaviour:
- Reset state: out_valid=0, out_data=0, out_ch=0, out_sat=0, sat_flags=0, internal valids=0. in_ready=1 as soon as rst is deasserted.
- Pipeline has 2 register stages.
  - S1: rounding add and shift, held in an IN_W+1 bit intermediate so the rounding carry never wraps.
  - S2: saturate and register outputs.
- Latency: 2 cycles from accepted input to out_valid when unstalled. Throughput is 1 sample/cycle.
- Global stall: en = ~out_valid | out_ready; in_ready = en. When en=0, all stages hold and out_* stay stable.
- Input transfer occurs on in_valid & in_ready. Output transfer occurs on out_valid & out_ready.
- Bubbles propagate: an S1 valid of 0 advances as a bubble.
- Rounding, where r = 2^(SHIFT-1):
  - Half up: (x + r) >>> SHIFT.
  - Half even: (x + r - 1 + kept_lsb) >>> SHIFT.
  - Truncate: x >>> SHIFT.
  - For SHIFT=0, all modes return x.
- Saturation: take the shifted value y. If bits [top:OUT_W-1] are all 0 or all 1, out = y[OUT_W-1:0], out_sat = 0. Otherwise out = sign ? 100..0 : 011..1, out_sat = 1.
- Flag update on an output transfer with out_sat=1 and out_ch < NUM_CH: set sat_flags[out_ch].
- Simultaneous set and clr on the same bit: set wins, so the event is never lost.
- Reset mid-stream: in-flight samples are discarded and no output transfer occurs. Upstream must resend.

Optional Feature:
- Macro SAT_ROUND_PIPE_STATS_EN.
- When defined, adds output port sat_count (32 bits). It increments on every output transfer with out_sat=1, saturates at 0xFFFFFFFF (no wrap), and is cleared by any clr_flags bit. Clear and increment in the same cycle yield 1. Reset value is 0.
- When not defined, the port and counter are absent and the rest of the behaviour is identical.

Decomposition:
- Package sat_pkg:
  - rnd_mode encodings RND_TRUNC=0, RND_HALF_UP=1, RND_HALF_EVEN=2.
  - Function sat_clamp(value, OUT_W) used by S2.
- Natural sub-module: sat_round_stage, the purely combinational round/shift for one sample, reused by future multi-lane variants.
- Pipeline control and flags stay in the top.

Test Plan (IN_W=17, OUT_W=16, SHIFT=1, NUM_CH=4 unless stated):
- Half up, in=17'h0FFFF (65535), ch=2 → after 2 cycles out_data=16'h7FFF, out_sat=1, sat_flags=4'b0100.
- Half up, in=-65536 → out_data=16'h8000, out_sat=0. Same mode, in=-3 → out_data=-1 (16'hFFFF).
- Half even, in = 1, 3, 5, 7 → out_data = 0, 2, 2, 4. Truncate, in=-3 → -2.
- Back-to-back 8 samples with out_ready=0 for cycles 3–5 → no drop or duplicate, order preserved, out_* stable while stalled, in_ready=0 during the stall.
- Set flag on ch 1 while clr_flags=4'b0010 in the same cycle → flag stays 1. Clear alone next cycle → 0. With STATS_EN, sat_count shows the same-cycle clear+increment as 1.
- Assert rst with 2 samples in flight → out_valid=0 immediately (async), sat_flags=0, and no output appears after rst is released.
